hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage core; it sits in the ID stage beside `Control`. It detects load-use hazards and inserts bubbles by driving the `NoOp_i` input of `Control`. It holds PC and IF/ID during those bubbles, flushes IF/ID on a taken branch, and freezes the whole pipeline while the data memory has an outstanding access. An optional saturating counter records stall cycles for performance analysis.

## Interface
Parameters:
- `LOAD_STALL`, default 1: bubbles per load-use hazard.
  - Legal range 1..3.
  - 1 means full forwarding from MEM/WB.
  - 2 or 3 is for builds with reduced forwarding.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk_i` input 1: the single clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `RS1addr_i` input 5: rs1 field of the instruction in IF/ID.
- `RS2addr_i` input 5: rs2 field of the instruction in IF/ID.
- `ID_EX_MemRead_i` input 1: the instruction in EX is a load.
- `ID_EX_RDaddr_i` input 5: rd of the instruction in EX.
- `Branch_i` input 1: the branch in ID resolved taken this cycle.
- `MemReq_i` input 1: the MEM stage has a data-memory access in flight.
- `MemAck_i` input 1: the data-memory access completes this cycle.
- `NoOp_o` output 1: to `Control.NoOp_i`; zeroes ID/EX control, which inserts a bubble.
- `Stall_o` output 1: IF/ID register holds its contents.
- `PCWrite_o` output 1: PC register update enable.
- `Flush_o` output 1: IF/ID is cleared to a NOP.
- `MemStall_o` output 1: freeze enable for all pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- `StallCnt_o` output `CNT_W`: number of cycles in which `Stall_o` was high.

## Operation
Definitions:
- `freeze = MemReq_i & ~MemAck_i`.
- `lu_hit = ID_EX_MemRead_i & (ID_EX_RDaddr_i != 0) & (ID_EX_RDaddr_i == RS1addr_i | ID_EX_RDaddr_i == RS2addr_i)`.

FSM states:
- RUN: no bubble pending.
- LU_STALL: extra bubbles are still owed. A 2-bit `lu_cnt` holds the number of bubbles remaining.

Output priority, evaluated combinationally each cycle (Mealy outputs, first match wins):
1. `freeze`:
   - `MemStall_o=1`, `Stall_o=1`, `PCWrite_o=0`, `NoOp_o=0`, `Flush_o=0`.
   - State, `lu_cnt` and the latched rd all hold.
2. State LU_STALL:
   - `NoOp_o=1`, `Stall_o=1`, `PCWrite_o=0`, `Flush_o=0`, regardless of `lu_hit` and `Branch_i`.
   - `lu_cnt` decrements. The FSM returns to RUN when `lu_cnt` reaches 0.
3. RUN with `lu_hit`:
   - `NoOp_o=1`, `Stall_o=1`, `PCWrite_o=0`, `Flush_o=0`.
   - If `LOAD_STALL>1`: go to LU_STALL with `lu_cnt = LOAD_STALL-1`.
4. RUN with `Branch_i`:
   - `Flush_o=1`, `PCWrite_o=1`, all other outputs 0.
5. Otherwise: `PCWrite_o=1`, all other outputs 0.

Boundary conditions:
- A load-use hazard on the same cycle as `Branch_i` resolves as a stall. The branch is re-evaluated once its operands are valid.
- `rd = x0` never causes a stall.
- `MemReq_i` must stay high until the cycle in which `MemAck_i` is asserted. `MemAck_i` is ignored when `MemReq_i` is low.
- `MemAck_i` in the same cycle as `MemReq_i` rises gives zero freeze cycles.
- Out-of-range `LOAD_STALL` values are clamped to 1..3 at elaboration.

## Timing
- Reset value of every output while `rst_i` is low: 0, including `PCWrite_o` and `StallCnt_o`. The FSM is in RUN with `lu_cnt=0`.
- First cycle after reset release with quiet inputs: `PCWrite_o=1`.
- Hazard response is zero-latency: outputs react in the same cycle as the inputs.
- A load-use hazard detected in cycle N produces `NoOp_o` high in cycles N .. N+LOAD_STALL-1 (with no freeze in between).
- A freeze lasting F cycles extends the above window by exactly F cycles.
- `MemStall_o` deasserts combinationally in the cycle `MemAck_i` is high.
- `Flush_o` is a single-cycle pulse per taken branch.
- Reset asserted mid-stall immediately forces all outputs to 0 and clears the FSM and counter. No bubble is carried over after reset.

## Configuration
- Macro: `HAZARD_PERF_EN`.
- Defined:
  - `StallCnt_o` increments by 1 on every rising edge where `Stall_o=1`, whatever the cause.
  - The count saturates at `2^CNT_W-1`.
  - It clears only on reset.
- Undefined:
  - `StallCnt_o` is tied to 0 and no counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Load-use, `LOAD_STALL=1`: `ID_EX_MemRead_i=1`, `ID_EX_RDaddr_i=5`, `RS1addr_i=5` for one cycle -> `NoOp_o`/`Stall_o` high and `PCWrite_o` low for exactly 1 cycle, then `PCWrite_o=1`.
- Load-use, `LOAD_STALL=3`: the same stimulus, with the EX inputs cleared after 1 cycle -> 3 consecutive bubble cycles, then RUN.
- x0 and no-match cases: `ID_EX_RDaddr_i=0` matching `RS2addr_i=0`, and separately `ID_EX_RDaddr_i=7` with `RS1addr_i=3`, `RS2addr_i=4` -> no stall in either case.
- Branch versus hazard:
  - `Branch_i=1` alone -> 1-cycle `Flush_o`.
  - `Branch_i=1` together with `lu_hit` -> `Flush_o=0` and a stall.
  - `Branch_i` held for the next cycle -> flush occurs in that cycle.
- Memory freeze during LU_STALL (`LOAD_STALL=2`): `MemReq_i=1` for 4 cycles with `MemAck_i` in the 4th -> `MemStall_o` high for 3 cycles; the remaining bubble is issued after the ack; `StallCnt_o=5` with `HAZARD_PERF_EN` defined.
- Async reset mid-LU_STALL: drop `rst_i` between clock edges -> all outputs 0 immediately; after release, `PCWrite_o=1` with no residual bubble, and `StallCnt_o=0`.

Source files
------------

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_if
// Description : ID-stage hazard controller bus: operand/hazard inputs in,
//               pipeline stall/flush/freeze controls and stall count out.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       RS1addr_i;
  logic [4:0]       RS2addr_i;
  logic             ID_EX_MemRead_i;
  logic [4:0]       ID_EX_RDaddr_i;
  logic             Branch_i;
  logic             MemReq_i;
  logic             MemAck_i;
  logic             NoOp_o;
  logic             Stall_o;
  logic             PCWrite_o;
  logic             Flush_o;
  logic             MemStall_o;
  logic [CNT_W-1:0] StallCnt_o;

  // Pipeline side: drives the hazard inputs, consumes the controls.
  modport master (
    output RS1addr_i, RS2addr_i, ID_EX_MemRead_i, ID_EX_RDaddr_i,
           Branch_i, MemReq_i, MemAck_i,
    input  NoOp_o, Stall_o, PCWrite_o, Flush_o, MemStall_o, StallCnt_o
  );

  modport slave (
    input  RS1addr_i, RS2addr_i, ID_EX_MemRead_i, ID_EX_RDaddr_i,
           Branch_i, MemReq_i, MemAck_i,
    output NoOp_o, Stall_o, PCWrite_o, Flush_o, MemStall_o, StallCnt_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use bubble insertion, branch flush and data-memory freeze
//               for the five-stage core. HAZARD_PERF_EN enables the stall
//               cycle counter on StallCnt_o (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  hazard_unit_if.slave bus
);

  localparam int c_load_stall = (LOAD_STALL < 1) ? 1 :
                                (LOAD_STALL > 3) ? 3 : LOAD_STALL;
  localparam logic [1:0] c_lu_init = 2'(c_load_stall - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_lu_cnt;

  logic w_freeze;
  logic w_lu_hit;
  logic w_noop;
  logic w_stall;
  logic w_pc_write;
  logic w_flush;
  logic w_mem_stall;

  assign w_freeze = bus.MemReq_i & ~bus.MemAck_i;
  assign w_lu_hit = bus.ID_EX_MemRead_i
                  & (bus.ID_EX_RDaddr_i != 5'd0)
                  & ((bus.ID_EX_RDaddr_i == bus.RS1addr_i) |
                     (bus.ID_EX_RDaddr_i == bus.RS2addr_i));

  // Controls are Mealy so the hazard is answered in the cycle it appears;
  // reset gates them so nothing leaks out while rst_i is low.
  always_comb begin
    w_noop      = 1'b0;
    w_stall     = 1'b0;
    w_pc_write  = 1'b0;
    w_flush     = 1'b0;
    w_mem_stall = 1'b0;
    if (rst_i) begin
      if (w_freeze) begin
        w_mem_stall = 1'b1;
        w_stall     = 1'b1;
      end else if (r_state == LU_STALL) begin
        w_noop  = 1'b1;
        w_stall = 1'b1;
      end else if (w_lu_hit) begin
        w_noop  = 1'b1;
        w_stall = 1'b1;
      end else if (bus.Branch_i) begin
        w_flush    = 1'b1;
        w_pc_write = 1'b1;
      end else begin
        w_pc_write = 1'b1;
      end
    end
  end

  // A freeze holds the bubble bookkeeping so owed bubbles resume afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= RUN;
      r_lu_cnt <= 2'd0;
    end else if (!w_freeze) begin
      case (r_state)
        LU_STALL: begin
          r_lu_cnt <= r_lu_cnt - 2'd1;
          if (r_lu_cnt <= 2'd1) begin
            r_state <= RUN;
          end
        end
        default: begin
          if (w_lu_hit && (c_load_stall > 1)) begin
            r_state  <= LU_STALL;
            r_lu_cnt <= c_lu_init;
          end
        end
      endcase
    end
  end

  assign bus.NoOp_o     = w_noop;
  assign bus.Stall_o    = w_stall;
  assign bus.PCWrite_o  = w_pc_write;
  assign bus.Flush_o    = w_flush;
  assign bus.MemStall_o = w_mem_stall;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.StallCnt_o = r_stall_cnt;
`else
  assign bus.StallCnt_o = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire
